// File: rtl/hnf_pcrd_grant_ctl_pkg.sv
// Shared defaults and FSM encodings for the HN-F PCrdGrant controller.
package hnf_pcrd_grant_ctl_pkg;

    localparam int HNF_MSHR_RNF_NUM_PARAM = 4;
    localparam int HNF_PCRD_CNT_WIDTH     = 4;
    localparam int HNF_SRCID_WIDTH        = 11;
    localparam int HNF_RNF_IDX_WIDTH      = 2;

    typedef enum logic {
        HNF_PCRD_IDLE = 1'b0,
        HNF_PCRD_SEND = 1'b1
    } hnf_pcrd_state_e;

endpackage

// File: rtl/hnf_pcrd_grant_ctl_onehot2idx.sv
// One-hot to binary index by OR-reduction; a zero vector yields index 0.
module hnf_onehot2idx #(
    parameter int RNF_NUM   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [RNF_NUM-1:0]   onehot,
    output logic [IDX_WIDTH-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < RNF_NUM; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/hnf_pcrd_grant_ctl.sv
// Tracks PCrdGrants owed per RN-F after RetryAck and issues one grant per freed MSHR credit.
module hnf_pcrd_grant_ctl
    import hnf_pcrd_grant_ctl_pkg::*;
#(
    parameter int RNF_NUM     = HNF_MSHR_RNF_NUM_PARAM,
    parameter int CNT_WIDTH   = HNF_PCRD_CNT_WIDTH,
    parameter int SRCID_WIDTH = HNF_SRCID_WIDTH,
    parameter int IDX_WIDTH   = HNF_RNF_IDX_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           retry_sent_valid,
    input  logic [IDX_WIDTH-1:0]           retry_sent_idx,
    input  logic                           crd_avail,
    output logic                           crd_consume,
    output logic [RNF_NUM-1:0]             req_entry_vec,
    input  logic [RNF_NUM-1:0]             req_entry_ptr_sel,
    output logic                           upd_start_entry,
    input  logic [RNF_NUM*SRCID_WIDTH-1:0] rnf_srcid_tbl,
    output logic                           txrsp_pcrd_valid,
    input  logic                           txrsp_pcrd_ready,
    output logic [SRCID_WIDTH-1:0]         txrsp_pcrd_tgtid,
    output logic                           retry_cnt_ovf
);

    hnf_pcrd_state_e        state;
    logic                   decision;
    logic [IDX_WIDTH-1:0]   grant_idx;
    logic [RNF_NUM-1:0]     sat_hit;

    hnf_onehot2idx #(
        .RNF_NUM   (RNF_NUM),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_onehot2idx (
        .onehot (req_entry_ptr_sel),
        .idx    (grant_idx)
    );

    // A grant is decided only from IDLE, so back-to-back decisions are impossible.
    assign decision        = !rst && (state == HNF_PCRD_IDLE) && crd_avail && (|req_entry_vec);
    assign upd_start_entry = decision;
    assign crd_consume     = decision;

    for (genvar i = 0; i < RNF_NUM; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q;
        logic                 inc;
        logic                 dec;

        assign inc              = retry_sent_valid && (retry_sent_idx == IDX_WIDTH'(i));
        assign dec              = decision && (grant_idx == IDX_WIDTH'(i));
        assign req_entry_vec[i] = (cnt_q != '0);
        assign sat_hit[i]       = inc && !dec && (&cnt_q);

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (inc && !dec) begin
                if (!(&cnt_q)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (dec && !inc) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= HNF_PCRD_IDLE;
            txrsp_pcrd_valid <= 1'b0;
            txrsp_pcrd_tgtid <= '0;
            retry_cnt_ovf    <= 1'b0;
        end else begin
            if (|sat_hit) begin
                retry_cnt_ovf <= 1'b1;
            end
            case (state)
                HNF_PCRD_IDLE: begin
                    if (decision) begin
                        txrsp_pcrd_tgtid <= rnf_srcid_tbl[int'(grant_idx)*SRCID_WIDTH +: SRCID_WIDTH];
                        txrsp_pcrd_valid <= 1'b1;
                        state            <= HNF_PCRD_SEND;
                    end
                end
                HNF_PCRD_SEND: begin
                    if (txrsp_pcrd_ready) begin
                        txrsp_pcrd_valid <= 1'b0;
                        state            <= HNF_PCRD_IDLE;
                    end
                end
                default: begin
                    txrsp_pcrd_valid <= 1'b0;
                    state            <= HNF_PCRD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hnf_pcrd_grant_ctl.sv
// Directed bench for hnf_pcrd_grant_ctl with a round-robin selector model in the loop.
module tb_hnf_pcrd_grant_ctl;

    localparam int RNF_NUM     = 4;
    localparam int CNT_WIDTH   = 4;
    localparam int SRCID_WIDTH = 11;
    localparam int IDX_WIDTH   = 2;

    localparam logic [10:0] EXP_TGT [4] = '{11'h100, 11'h111, 11'h122, 11'h133};

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           retry_sent_valid;
    logic [IDX_WIDTH-1:0]           retry_sent_idx;
    logic                           crd_avail;
    logic                           crd_consume;
    logic [RNF_NUM-1:0]             req_entry_vec;
    logic [RNF_NUM-1:0]             req_entry_ptr_sel;
    logic                           upd_start_entry;
    logic [RNF_NUM*SRCID_WIDTH-1:0] rnf_srcid_tbl;
    logic                           txrsp_pcrd_valid;
    logic                           txrsp_pcrd_ready;
    logic [SRCID_WIDTH-1:0]         txrsp_pcrd_tgtid;
    logic                           retry_cnt_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rnf_srcid_tbl = {11'h133, 11'h122, 11'h111, 11'h100};

    hnf_pcrd_grant_ctl #(
        .RNF_NUM     (RNF_NUM),
        .CNT_WIDTH   (CNT_WIDTH),
        .SRCID_WIDTH (SRCID_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .retry_sent_valid  (retry_sent_valid),
        .retry_sent_idx    (retry_sent_idx),
        .crd_avail         (crd_avail),
        .crd_consume       (crd_consume),
        .req_entry_vec     (req_entry_vec),
        .req_entry_ptr_sel (req_entry_ptr_sel),
        .upd_start_entry   (upd_start_entry),
        .rnf_srcid_tbl     (rnf_srcid_tbl),
        .txrsp_pcrd_valid  (txrsp_pcrd_valid),
        .txrsp_pcrd_ready  (txrsp_pcrd_ready),
        .txrsp_pcrd_tgtid  (txrsp_pcrd_tgtid),
        .retry_cnt_ovf     (retry_cnt_ovf)
    );

    // Round-robin selector: first pending entry at or after the pointer.
    logic [1:0] rr_ptr;
    logic [3:0] sel;
    logic [1:0] sel_idx;

    always_comb begin
        sel     = '0;
        sel_idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (req_entry_vec[2'(rr_ptr + 2'(k))] && sel == 4'b0) begin
                sel[2'(rr_ptr + 2'(k))] = 1'b1;
                sel_idx                 = 2'(rr_ptr + 2'(k));
            end
        end
    end
    assign req_entry_ptr_sel = sel;

    always @(posedge clk) begin
        if (rst) rr_ptr <= 2'd0;
        else if (upd_start_entry) rr_ptr <= sel_idx + 2'd1;
    end

    int          upd_total = 0;
    int          b2b       = 0;
    logic        prev_upd  = 1'b0;
    logic [1:0]  grant_log [$];
    logic [10:0] flit_log  [$];

    always @(negedge clk) begin
        if (upd_start_entry) begin
            upd_total <= upd_total + 1;
            grant_log.push_back(sel_idx);
        end
        if (txrsp_pcrd_valid && txrsp_pcrd_ready) flit_log.push_back(txrsp_pcrd_tgtid);
        if (upd_start_entry && prev_upd) b2b <= b2b + 1;
        prev_upd <= upd_start_entry;
        if (!rst && !txrsp_pcrd_valid && crd_avail && (|req_entry_vec)) begin
            assert ($onehot(sel) && ((sel & ~req_entry_vec) == 4'b0))
            else $error("FAIL sel_onehot sel=%b vec=%b", sel, req_entry_vec);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        retry_sent_valid = 1'b0;
        retry_sent_idx   = '0;
        crd_avail        = 1'b0;
        txrsp_pcrd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gbase;
        int fbase;

        rst              = 1'b1;
        retry_sent_valid = 1'b0;
        retry_sent_idx   = '0;
        crd_avail        = 1'b0;
        txrsp_pcrd_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_valid", 32'(txrsp_pcrd_valid), 0);
        chk("rst_consume", 32'(crd_consume), 0);
        chk("rst_upd", 32'(upd_start_entry), 0);
        chk("rst_ovf", 32'(retry_cnt_ovf), 0);
        chk("rst_tgtid", 32'(txrsp_pcrd_tgtid), 0);
        chk("rst_vec", 32'(req_entry_vec), 0);
        rst = 1'b0;
        tick();

        // Single entry grant.
        base  = upd_total;
        fbase = flit_log.size();
        retry_sent_valid = 1'b1;
        retry_sent_idx   = 2'd2;
        crd_avail        = 1'b1;
        txrsp_pcrd_ready = 1'b1;
        tick();
        retry_sent_valid = 1'b0;
        @(negedge clk);
        chk("single_upd", 32'(upd_start_entry), 1);
        chk("single_consume", 32'(crd_consume), 1);
        chk("single_vec", 32'(req_entry_vec), 32'h4);
        tick();
        @(negedge clk);
        chk("single_valid", 32'(txrsp_pcrd_valid), 1);
        chk("single_tgtid", 32'(txrsp_pcrd_tgtid), 32'(EXP_TGT[2]));
        chk("single_vec_clr", 32'(req_entry_vec), 0);
        repeat (3) tick();
        @(negedge clk);
        chk("single_upd_cnt", 32'(upd_total - base), 1);
        chk("single_flit_cnt", 32'(int'(flit_log.size()) - fbase), 1);
        if (flit_log.size() > fbase) chk("single_flit_tgt", 32'(flit_log[fbase]), 32'(EXP_TGT[2]));

        // Fairness across four entries with three grants owed each.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            retry_sent_valid = 1'b1;
            retry_sent_idx   = 2'(k % 4);
            tick();
        end
        retry_sent_valid = 1'b0;
        @(negedge clk);
        chk("fair_vec_full", 32'(req_entry_vec), 32'hF);
        gbase = grant_log.size();
        fbase = flit_log.size();
        crd_avail        = 1'b1;
        txrsp_pcrd_ready = 1'b1;
        for (int c = 0; c < 60 && ((int'(grant_log.size()) - gbase) < 12 || txrsp_pcrd_valid); c++) tick();
        @(negedge clk);
        chk("fair_count", 32'(int'(grant_log.size()) - gbase), 12);
        for (int k = 0; k < 12; k++) begin
            if (gbase + k < grant_log.size()) chk($sformatf("fair_order%0d", k), 32'(grant_log[gbase + k]), 32'(k % 4));
            if (fbase + k < flit_log.size()) chk($sformatf("fair_tgt%0d", k), 32'(flit_log[fbase + k]), 32'(EXP_TGT[k % 4]));
        end
        chk("fair_vec_end", 32'(req_entry_vec), 0);

        // Backpressure holds the flit and blocks new decisions.
        do_reset();
        base             = upd_total;
        retry_sent_valid = 1'b1;
        retry_sent_idx   = 2'd1;
        crd_avail        = 1'b1;
        tick();
        retry_sent_idx = 2'd3;
        @(negedge clk);
        chk("bp_upd", 32'(upd_start_entry), 1);
        tick();
        retry_sent_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", c), 32'(txrsp_pcrd_valid), 1);
            chk($sformatf("bp_tgt%0d", c), 32'(txrsp_pcrd_tgtid), 32'(EXP_TGT[1]));
            chk($sformatf("bp_noupd%0d", c), 32'(upd_start_entry | crd_consume), 0);
            tick();
        end
        txrsp_pcrd_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", 32'(txrsp_pcrd_valid), 1);
        tick();
        @(negedge clk);
        chk("bp_idle_valid", 32'(txrsp_pcrd_valid), 0);
        chk("bp_next_upd", 32'(upd_start_entry), 1);
        chk("bp_next_vec", 32'(req_entry_vec), 32'h8);
        tick();
        @(negedge clk);
        chk("bp_next_tgt", 32'(txrsp_pcrd_tgtid), 32'(EXP_TGT[3]));
        tick();
        @(negedge clk);
        chk("bp_vec_end", 32'(req_entry_vec), 0);
        chk("bp_upd_cnt", 32'(upd_total - base), 2);

        // Retry and grant on the same entry in the same cycle.
        do_reset();
        txrsp_pcrd_ready = 1'b1;
        retry_sent_valid = 1'b1;
        retry_sent_idx   = 2'd1;
        tick();
        crd_avail = 1'b1;
        @(negedge clk);
        chk("simul_upd", 32'(upd_start_entry), 1);
        chk("simul_vec_pre", 32'(req_entry_vec), 32'h2);
        tick();
        retry_sent_valid = 1'b0;
        crd_avail        = 1'b0;
        @(negedge clk);
        chk("simul_vec_post", 32'(req_entry_vec), 32'h2);
        chk("simul_valid", 32'(txrsp_pcrd_valid), 1);
        repeat (3) tick();
        @(negedge clk);
        chk("simul_vec_hold", 32'(req_entry_vec), 32'h2);
        crd_avail = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("simul_vec_drain", 32'(req_entry_vec), 0);

        // Counter saturation and sticky overflow.
        do_reset();
        txrsp_pcrd_ready = 1'b1;
        retry_sent_valid = 1'b1;
        retry_sent_idx   = 2'd0;
        repeat (15) tick();
        @(negedge clk);
        chk("sat_ovf_pre", 32'(retry_cnt_ovf), 0);
        chk("sat_vec", 32'(req_entry_vec), 32'h1);
        tick();
        retry_sent_valid = 1'b0;
        @(negedge clk);
        chk("sat_ovf_set", 32'(retry_cnt_ovf), 1);
        base      = upd_total;
        crd_avail = 1'b1;
        for (int c = 0; c < 100 && (req_entry_vec != 4'b0 || txrsp_pcrd_valid); c++) tick();
        @(negedge clk);
        chk("sat_grants", 32'(upd_total - base), 15);
        chk("sat_ovf_hold", 32'(retry_cnt_ovf), 1);
        chk("sat_vec_end", 32'(req_entry_vec), 0);

        // Reset while a flit is pending.
        crd_avail        = 1'b0;
        txrsp_pcrd_ready = 1'b0;
        retry_sent_valid = 1'b1;
        retry_sent_idx   = 2'd2;
        tick();
        tick();
        retry_sent_valid = 1'b0;
        crd_avail        = 1'b1;
        @(negedge clk);
        chk("rsend_upd", 32'(upd_start_entry), 1);
        tick();
        @(negedge clk);
        chk("rsend_valid_pre", 32'(txrsp_pcrd_valid), 1);
        chk("rsend_vec_pre", 32'(req_entry_vec), 32'h4);
        chk("rsend_ovf_pre", 32'(retry_cnt_ovf), 1);
        rst = 1'b1;
        tick();
        rst              = 1'b0;
        txrsp_pcrd_ready = 1'b1;
        @(negedge clk);
        chk("rsend_valid", 32'(txrsp_pcrd_valid), 0);
        chk("rsend_vec", 32'(req_entry_vec), 0);
        chk("rsend_ovf", 32'(retry_cnt_ovf), 0);
        chk("rsend_tgtid", 32'(txrsp_pcrd_tgtid), 0);
        fbase = flit_log.size();
        repeat (3) tick();
        @(negedge clk);
        chk("rsend_no_flit", 32'(int'(flit_log.size()) - fbase), 0);
        retry_sent_valid = 1'b1;
        retry_sent_idx   = 2'd0;
        tick();
        retry_sent_valid = 1'b0;
        @(negedge clk);
        chk("rsend_idle_upd", 32'(upd_start_entry), 1);
        repeat (3) tick();

        chk("no_back_to_back", 32'(b2b), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
